// File: rtl/dec_stream_pkg.sv
// Shared types and constants for the multi-channel stream packetizer.
// Status word layout is {len, ip, mac} with mac in the low bits.
package dec_stream_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HDR,
        S_SEND,
        S_GAP,
        S_STATUS
    } state_t;

    localparam int HDR_BYTES = 2;
    localparam int MAC_LSB   = 0;

    function automatic int ip_lsb(input int mac_size);
        return mac_size;
    endfunction

    function automatic int len_lsb(input int mac_size, input int ip_size);
        return mac_size + ip_size;
    endfunction

endpackage

// File: rtl/dec_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after ptr, wrapping.
// Returns a one-hot grant, its index and a valid flag.
module dec_rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    always_comb begin
        int c;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        c     = 0;
        for (int i = 1; i <= N; i++) begin
            c = (int'(ptr) + i) % N;
            if (!valid && req[c]) begin
                valid    = 1'b1;
                grant[c] = 1'b1;
                idx      = IW'(c);
            end
        end
    end

endmodule

// File: rtl/dec_stream_packetizer.sv
// Drains N_CH show-ahead FIFOs round-robin into the GbE TX data/status FIFOs.
// Define DEC_STREAM_CH_HEADER_EN to prefix each payload with {channel id, seq}.
module dec_stream_packetizer
    import dec_stream_pkg::*;
#(
    parameter int AVL_SIZE      = 8,
    parameter int BYTE_SIZE     = 8,
    parameter int IP_SIZE       = 32,
    parameter int MAC_SIZE      = 48,
    parameter int N_CH          = 2,
    parameter int WORD_BYTES    = 8,
    parameter int WORDS_PER_PKT = 4
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    output logic [AVL_SIZE-1:0]                    tx_fifo_data,
    output logic [2*BYTE_SIZE+IP_SIZE+MAC_SIZE-1:0] tx_fifo_status,
    output logic                                   tx_fifo_data_write,
    output logic                                   tx_fifo_status_write,
    input  logic                                   tx_fifo_data_full,
    input  logic                                   tx_fifo_status_full,
    input  logic [MAC_SIZE-1:0]                    destination_mac,
    input  logic [IP_SIZE-1:0]                     destination_ip,
    input  logic [N_CH-1:0]                        channel_en,
    output logic [N_CH-1:0]                        fifo_clr,
    output logic [N_CH-1:0]                        fifo_rdreq,
    input  logic [N_CH-1:0]                        fifo_rdempty,
    input  logic [N_CH*WORD_BYTES*8-1:0]           fifo_rddata,
    output logic                                   busy
);

    localparam int IW      = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int BW      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int WCW     = $clog2(WORDS_PER_PKT + 1);
    localparam int WW      = WORD_BYTES * 8;
    localparam int LEN_W   = 2 * BYTE_SIZE;
    localparam int SW      = LEN_W + IP_SIZE + MAC_SIZE;
    localparam int IP_LSB  = ip_lsb(MAC_SIZE);
    localparam int LEN_LSB = len_lsb(MAC_SIZE, IP_SIZE);
`ifdef DEC_STREAM_CH_HEADER_EN
    localparam int HDR_ADD = HDR_BYTES;
`else
    localparam int HDR_ADD = 0;
`endif

    state_t            state;
    logic [IW-1:0]     sel;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     gnt_idx;
    logic [N_CH-1:0]   gnt;
    logic              gnt_valid;
    logic [N_CH-1:0]   elig;
    logic [WW-1:0]     shreg;
    logic [WW-1:0]     word_in;
    logic [BW-1:0]     byte_idx;
    logic [WCW-1:0]    word_cnt;
    logic [IP_SIZE-1:0]  ip_q;
    logic [MAC_SIZE-1:0] mac_q;
    logic [7:0]        tx_byte;
`ifdef DEC_STREAM_CH_HEADER_EN
    logic [7:0]        seq [N_CH];
    logic              hdr_idx;
`endif

    assign elig    = channel_en & ~fifo_rdempty;
    assign word_in = fifo_rddata[int'(sel)*WW +: WW];
    assign busy    = (state != S_IDLE);

    dec_rr_arbiter #(.N(N_CH), .IW(IW)) u_arb (
        .req   (elig),
        .ptr   (rr_ptr),
        .grant (gnt),
        .idx   (gnt_idx),
        .valid (gnt_valid)
    );

    function automatic logic [N_CH-1:0] onehot(input logic [IW-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    function automatic logic [SW-1:0] pack_status(
        input logic [WCW-1:0]      n,
        input logic [IP_SIZE-1:0]  ip,
        input logic [MAC_SIZE-1:0] mac
    );
        pack_status = '0;
        pack_status[LEN_LSB +: LEN_W] =
            LEN_W'(n) * LEN_W'(WORD_BYTES) + LEN_W'(HDR_ADD);
        pack_status[IP_LSB +: IP_SIZE]   = ip;
        pack_status[MAC_LSB +: MAC_SIZE] = mac;
    endfunction

    // Byte strobe must follow data_full in the same cycle, so it is decoded.
    always_comb begin
        tx_byte = '0;
        if (state == S_SEND) begin
            tx_byte = shreg[WW-1 -: 8];
        end
`ifdef DEC_STREAM_CH_HEADER_EN
        else if (state == S_HDR) begin
            tx_byte = hdr_idx ? seq[sel] : 8'(sel);
        end
`endif
    end

    assign tx_fifo_data       = AVL_SIZE'(tx_byte);
    assign tx_fifo_data_write = (state == S_SEND || state == S_HDR) &&
                                !tx_fifo_data_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                <= S_IDLE;
            sel                  <= '0;
            rr_ptr               <= IW'(N_CH - 1);
            shreg                <= '0;
            byte_idx             <= '0;
            word_cnt             <= '0;
            ip_q                 <= '0;
            mac_q                <= '0;
            fifo_rdreq           <= '0;
            fifo_clr             <= '1;
            tx_fifo_status_write <= 1'b0;
            tx_fifo_status       <= '0;
`ifdef DEC_STREAM_CH_HEADER_EN
            hdr_idx              <= 1'b0;
            for (int i = 0; i < N_CH; i++) seq[i] <= '0;
`endif
        end else begin
            fifo_clr             <= ~channel_en;
            fifo_rdreq           <= '0;
            tx_fifo_status_write <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (!tx_fifo_status_full && gnt_valid) begin
                        sel        <= gnt_idx;
                        ip_q       <= destination_ip;
                        mac_q      <= destination_mac;
                        word_cnt   <= '0;
                        fifo_rdreq <= gnt;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    shreg    <= word_in;
                    word_cnt <= word_cnt + 1'b1;
                    byte_idx <= '0;
`ifdef DEC_STREAM_CH_HEADER_EN
                    hdr_idx  <= 1'b0;
                    state    <= (word_cnt == '0) ? S_HDR : S_SEND;
`else
                    state    <= S_SEND;
`endif
                end
`ifdef DEC_STREAM_CH_HEADER_EN
                S_HDR: begin
                    if (!tx_fifo_data_full) begin
                        hdr_idx <= ~hdr_idx;
                        if (hdr_idx) state <= S_SEND;
                    end
                end
`endif
                S_SEND: begin
                    if (!tx_fifo_data_full) begin
                        shreg    <= shreg << 8;
                        byte_idx <= byte_idx + 1'b1;
                        if (byte_idx == BW'(WORD_BYTES - 1)) begin
                            if (word_cnt < WCW'(WORDS_PER_PKT)) begin
                                state <= S_GAP;
                            end else begin
                                tx_fifo_status_write <= 1'b1;
                                tx_fifo_status <= pack_status(word_cnt, ip_q, mac_q);
                                state <= S_STATUS;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (elig[sel]) begin
                        fifo_rdreq <= onehot(sel);
                        state      <= S_LOAD;
                    end else begin
                        tx_fifo_status_write <= 1'b1;
                        tx_fifo_status <= pack_status(word_cnt, ip_q, mac_q);
                        state <= S_STATUS;
                    end
                end
                S_STATUS: begin
                    rr_ptr <= sel;
`ifdef DEC_STREAM_CH_HEADER_EN
                    seq[sel] <= seq[sel] + 8'd1;
`endif
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
